// File: rtl/led_arb_pkg.sv
// Shared types and constants for the LED arbiter.
//   arb_state_e         : arbiter state (IDLE shows heartbeat, HOLD shows a granted pattern)
//   LED_W               : number of onboard LEDs
//   HOLD_CYCLES_DEFAULT : default minimum grant time (0.5 s at 50 MHz)
package led_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  localparam int unsigned LED_W               = 8;
  localparam int unsigned HOLD_CYCLES_DEFAULT = 25_000_000;

endpackage

// File: rtl/rr_pick.sv
// Combinational circular first-one finder.
// Searches req_i starting at last_i+1 and wrapping; last_i itself is the
// final candidate, so a lone requester equal to last_i is still found.
//   req_i   : request vector
//   last_i  : index searched after (previous winner)
//   valid_o : some request bit is set
//   idx_o   : winning index (0 when valid_o is low)
module rr_pick #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] last_i,
  output logic                     valid_o,
  output logic [$clog2(N_REQ)-1:0] idx_o
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] cand;

  // Walk candidates from farthest to nearest so the nearest asserted one wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int unsigned k = N_REQ; k >= 1; k--) begin
      cand = IDX_W'((32'(last_i) + k) % N_REQ);
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/led_arbiter.sv
// Round-robin owner of the 8 onboard LEDs with a minimum visible hold time.
// Idle: led[0] shows the heartbeat counter MSB. Busy: led shows the granted
// requester's pattern, tracking it live while its request stays high and
// freezing when it drops, until the hold time runs out.
// Optional build macro LED_ARB_PREEMPT_EN: a rising req[0] steals the grant
// from any other holder on the next cycle.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   req     : per-requester request level
//   pattern : requester i pattern on [8i+7:8i]
//   grant   : registered one-hot grant, zero when idle
//   led     : registered LED drive
//   busy    : high while a grant is held
module led_arbiter
  import led_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
  parameter int unsigned HB_BITS     = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [LED_W*N_REQ-1:0] pattern,
  output logic [N_REQ-1:0]       grant,
  output logic [LED_W-1:0]       led,
  output logic                   busy
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_RESET  = IDX_W'(N_REQ - 1);

  arb_state_e         state_q;
  logic [N_REQ-1:0]   grant_q;
  logic [LED_W-1:0]   led_q;
  logic               busy_q;
  logic [CNT_W-1:0]   hold_q;
  logic [HB_BITS-1:0] hb_q;
  logic [HB_BITS-1:0] hb_d;
  // Last winner; while in HOLD this is also the current owner's index.
  logic [IDX_W-1:0]   last_q;

  logic               pick_valid_c;
  logic [IDX_W-1:0]   pick_idx_c;
  logic [LED_W-1:0]   pick_pat_c;
  logic [LED_W-1:0]   cur_pat_c;
  logic [LED_W-1:0]   hb_led_c;
  logic               preempt_c;

  assign grant = grant_q;
  assign led   = led_q;
  assign busy  = busy_q;

  assign hb_d     = hb_q + HB_BITS'(1);
  assign hb_led_c = {{(LED_W-1){1'b0}}, hb_d[HB_BITS-1]};

  // Searching after the current owner yields the rotation target at expiry,
  // falling back to the owner itself when it is the only one still asking.
  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req_i   (req),
    .last_i  (last_q),
    .valid_o (pick_valid_c),
    .idx_o   (pick_idx_c)
  );

  // Pattern muxes: only the selected slice is read, so X on others is masked.
  always_comb begin
    cur_pat_c  = '0;
    pick_pat_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (IDX_W'(i) == last_q)     cur_pat_c  = pattern[i*LED_W +: LED_W];
      if (IDX_W'(i) == pick_idx_c) pick_pat_c = pattern[i*LED_W +: LED_W];
    end
  end

`ifdef LED_ARB_PREEMPT_EN
  logic req0_q;
  // Edge-triggered so a requester 0 that is already waiting does not
  // starve others through ordinary round-robin turns.
  assign preempt_c = (state_q == HOLD) && !grant_q[0] && req[0] && !req0_q;
`else
  assign preempt_c = 1'b0;
`endif

  // Arbiter FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      hold_q  <= '0;
      hb_q    <= '0;
      last_q  <= LAST_RESET;
`ifdef LED_ARB_PREEMPT_EN
      req0_q  <= 1'b0;
`endif
    end else begin
      hb_q <= hb_d;
`ifdef LED_ARB_PREEMPT_EN
      req0_q <= req[0];
`endif
      case (state_q)
        IDLE: begin
          if (pick_valid_c) begin
            state_q <= HOLD;
            grant_q <= N_REQ'(1) << pick_idx_c;
            busy_q  <= 1'b1;
            hold_q  <= HOLD_RELOAD;
            last_q  <= pick_idx_c;
            led_q   <= pick_pat_c;
          end else begin
            led_q <= hb_led_c;
          end
        end
        HOLD: begin
          if (preempt_c) begin
            grant_q <= N_REQ'(1);
            hold_q  <= HOLD_RELOAD;
            last_q  <= '0;
            led_q   <= pattern[LED_W-1:0];
          end else if (hold_q == '0) begin
            if (pick_valid_c) begin
              grant_q <= N_REQ'(1) << pick_idx_c;
              hold_q  <= HOLD_RELOAD;
              last_q  <= pick_idx_c;
              led_q   <= pick_pat_c;
            end else begin
              state_q <= IDLE;
              grant_q <= '0;
              busy_q  <= 1'b0;
              led_q   <= hb_led_c;
            end
          end else begin
            hold_q <= hold_q - CNT_W'(1);
            if (req[last_q]) led_q <= cur_pat_c;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_arbiter.sv
// Self-checking bench for led_arbiter (N_REQ=4, HOLD_CYCLES=4, HB_BITS=4).
module tb_led_arbiter;

  localparam int N    = 4;
  localparam int HOLD = 4;
  localparam int HB   = 4;
`ifdef LED_ARB_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] pattern = '0;
  logic [3:0]  grant;
  logic [7:0]  led;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  led_arbiter #(
    .N_REQ       (N),
    .HOLD_CYCLES (HOLD),
    .HB_BITS     (HB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .pattern (pattern),
    .grant   (grant),
    .led     (led),
    .busy    (busy)
  );

  // Reference model: owner (-1 = nobody), age = cycles the owner has been
  // shown, cyc = cycles since reset (heartbeat = cyc mod 2^HB).
  int          owner = -1;
  int          age   = 0;
  int          last  = N - 1;
  int unsigned cyc   = 0;
  logic [7:0]  m_led = '0;
  logic        m_req0 = 1'b0;
  logic [3:0]  exp_grant;
  logic        exp_busy;

  function automatic int next_after(input logic [3:0] r, input int from);
    for (int k = 1; k <= N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic give(input int n);
    owner = n;
    last  = n;
    age   = 1;
    m_led = pattern[n*8 +: 8];
  endtask

  always @(posedge clk) begin
    int   n;
    logic hb_msb;
    if (rst) begin
      owner = -1; age = 0; last = N - 1; cyc = 0; m_led = '0; m_req0 = 1'b0;
    end else begin
      cyc    = cyc + 1;
      hb_msb = (cyc % (2**HB)) >= (2**(HB-1));
      if (owner < 0) begin
        n = next_after(req, last);
        if (n >= 0) give(n);
        else m_led = {7'b0, hb_msb};
      end else if (PREEMPT && owner != 0 && req[0] && !m_req0) begin
        give(0);
      end else if (age >= HOLD) begin
        n = next_after(req, owner);
        if (n >= 0) give(n);
        else begin owner = -1; m_led = {7'b0, hb_msb}; end
      end else begin
        age = age + 1;
        if (req[owner]) m_led = pattern[owner*8 +: 8];
      end
      m_req0 = req[0];
    end
    exp_grant = (owner < 0) ? 4'b0 : 4'(1 << owner);
    exp_busy  = (owner >= 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; pattern = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; pattern = '0;
    tick(); tick();
    checks++;
    if ({grant, led, busy} !== 13'b0) begin
      failures++;
      $display("FAIL reset grant=%b led=%h busy=%b expected all zero", grant, led, busy);
    end
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if ({grant, busy, led[7:1]} !== 12'b0 || led[0] !== 1'((k % 16) >= 8)) begin
        failures++;
        $display("FAIL idle_heartbeat k=%0d grant=%b busy=%b led=%h expected led0=%0d", k, grant, busy, led, (k % 16) >= 8);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    pattern = $urandom;
    pattern[23:16] = 8'hA5;
    req = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (grant !== 4'b0100 || led !== 8'hA5 || busy !== 1'b1) begin
        failures++;
        $display("FAIL single k=%0d grant=%b led=%h busy=%b expected 0100/a5/1", k, grant, led, busy);
      end
    end
    req = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({grant, led, busy} !== {exp_grant, m_led, exp_busy}) begin
        failures++;
        $display("FAIL single_release k=%0d got %b/%h/%b expected %b/%h/%b", k, grant, led, busy, exp_grant, m_led, exp_busy);
      end
    end
  endtask

  task automatic test_round_robin();
    int o;
    do_reset();
    pattern = 32'h4433_2211;
    req = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      tick();
      o = (k / HOLD) % N;
      checks++;
      if (grant !== 4'(1 << o) || led !== 8'((o + 1) * 8'h11) || busy !== 1'b1) begin
        failures++;
        $display("FAIL round_robin k=%0d grant=%b led=%h busy=%b expected owner %0d", k, grant, led, busy, o);
      end
    end
  endtask

  task automatic test_drop_freeze();
    do_reset();
    req = 4'b0010;
    pattern = 32'h0000_3C00;
    tick();
    checks++;
    if (grant !== 4'b0010 || led !== 8'h3C) begin
      failures++;
      $display("FAIL drop_grant grant=%b led=%h expected 0010/3c", grant, led);
    end
    tick();
    req = '0;
    pattern = 32'h0000_FF00;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (grant !== 4'b0010 || led !== 8'h3C || busy !== 1'b1) begin
        failures++;
        $display("FAIL drop_freeze k=%0d grant=%b led=%h busy=%b expected 0010/3c/1", k, grant, led, busy);
      end
    end
    tick();
    checks++;
    if (grant !== 4'b0 || busy !== 1'b0 || led !== {7'b0, m_led[0]}) begin
      failures++;
      $display("FAIL drop_idle grant=%b led=%h busy=%b expected 0000/%h/0", grant, led, busy, {7'b0, m_led[0]});
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    req = 4'b0100;
    pattern = 32'h00A5_0000;
    tick(); tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({grant, led, busy} !== 13'b0) begin
      failures++;
      $display("FAIL mid_reset grant=%b led=%h busy=%b expected all zero", grant, led, busy);
    end
    rst = 1'b0;
    req = 4'b1001;
    pattern = 32'h7700_0055;
    tick();
    checks++;
    if (grant !== 4'b0001 || led !== 8'h55 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_first grant=%b led=%h expected 0001/55", grant, led);
    end
    repeat (HOLD) tick();
    checks++;
    if (grant !== 4'b1000 || led !== 8'h77) begin
      failures++;
      $display("FAIL mid_reset_rotate grant=%b led=%h expected 1000/77", grant, led);
    end
  endtask

  task automatic test_preempt();
    do_reset();
    req = 4'b0100;
    pattern = 32'h00C3_0099;
    tick(); tick();
    req = 4'b0101;
    tick();
    checks++;
    if (grant !== (PREEMPT ? 4'b0001 : 4'b0100) || led !== (PREEMPT ? 8'h99 : 8'hC3)) begin
      failures++;
      $display("FAIL preempt grant=%b led=%h expected %b/%h", grant, led,
               PREEMPT ? 4'b0001 : 4'b0100, PREEMPT ? 8'h99 : 8'hC3);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if ({grant, led, busy} !== {exp_grant, m_led, exp_busy}) begin
        failures++;
        $display("FAIL preempt_after k=%0d got %b/%h/%b expected %b/%h/%b", k, grant, led, busy, exp_grant, m_led, exp_busy);
      end
    end
  endtask

  // Random traffic; patterns of idle requesters are X and must never show.
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        if (req[i]) pattern[i*8 +: 8] = 8'($urandom);
        else        pattern[i*8 +: 8] = 8'hxx;
      end
      rst = ($urandom_range(0, 99) == 0);
      tick();
      checks++;
      if ({grant, led, busy} !== {exp_grant, m_led, exp_busy}) begin
        failures++;
        $display("FAIL random c=%0d got %b/%h/%b expected %b/%h/%b", c, grant, led, busy, exp_grant, m_led, exp_busy);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_drop_freeze();
    test_reset_mid_hold();
    test_preempt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
